receive: RTL

UART receive stage for the 8N1 serial link. Consumes the serial line driven by the far-end transmitter, oversamples it at 16x the bit rate using a baud-enable strobe from the shared baud generator, and deserialises one start bit, 8 data bits (LSB first) and one stop bit. The completed byte is presented on a parallel holding register with a receive-data-available flag, plus framing and overrun status, for the bus interface to read.

---
 rtl/receive.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/receive.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, byte holding register with rda/framing/overrun status.
// Define RECEIVE_MAJORITY_EN to take each bit as a 3-sample majority vote (samples 6, 7, 8) instead of the single sample 8.
module receive (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_baud,
  input  logic       rx_read_en,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_state;
  logic [3:0] r_scnt;
  logic [3:0] r_fcnt;
  logic       r_armed;
  logic [7:0] r_shift;
  logic [7:0] r_rx_data;
  logic       r_rda;
  logic       r_framing_err;
  logic       r_overrun_err;

  logic w_rxd_s;
  logic w_tick;
  logic w_decide;
  logic w_bit;
  logic w_done;
  logic w_start_edge;

  assign w_rxd_s      = r_sync2;
  assign w_tick       = rx_baud && (r_state != S_IDLE);
  assign w_decide     = w_tick && (r_scnt == 4'd8);
  assign w_done       = w_decide && (r_state == S_STOP);
  assign w_start_edge = (r_state == S_IDLE) && r_armed && !w_rxd_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

`ifdef RECEIVE_MAJORITY_EN
  logic r_h6;
  logic r_h7;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h6 <= 1'b1;
      r_h7 <= 1'b1;
    end else if (w_tick) begin
      if (r_scnt == 4'd6) r_h6 <= w_rxd_s;
      if (r_scnt == 4'd7) r_h7 <= w_rxd_s;
    end
  end

  // The third vote is the live sample on the decision tick itself.
  assign w_bit = (r_h6 & r_h7) | (r_h6 & w_rxd_s) | (r_h7 & w_rxd_s);
`else
  assign w_bit = w_rxd_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt <= 4'd0;
      r_fcnt <= 4'd0;
    end else if (w_start_edge) begin
      r_scnt <= 4'd0;
      r_fcnt <= 4'd0;
    end else if (w_tick) begin
      r_scnt <= r_scnt + 4'd1;
      if (r_scnt == 4'd15) r_fcnt <= r_fcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_shift <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A falling edge only counts once the line has been seen idle high.
          if (w_rxd_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_decide) r_state <= w_bit ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (w_decide) begin
            r_shift <= {w_bit, r_shift[7:1]};
            if (r_fcnt == 4'd8) r_state <= S_STOP;
          end
        end
        default: begin
          if (w_decide) r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data     <= 8'h00;
      r_rda         <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else if (w_done) begin
      // A read landing on the completion cycle consumes the old byte, so no overrun.
      r_rx_data     <= r_shift;
      r_rda         <= 1'b1;
      r_framing_err <= ~w_bit;
      r_overrun_err <= r_rda & ~rx_read_en;
    end else if (rx_read_en && r_rda) begin
      r_rda         <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end
  end

  assign rx_data     = r_rx_data;
  assign rda         = r_rda;
  assign framing_err = r_framing_err;
  assign overrun_err = r_overrun_err;

endmodule
